sobel_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel edge stage. It accepts one raster-order pixel per handshake and buffers two image lines internally. For every interior pixel it emits the full 3x3 window (P0..P8, row-major) with the window-centre coordinates, so the edge stage never random-accesses image memory. Border pixels (row 0, row H-1, col 0, col W-1) never become window centres.

---
 rtl/sobel_window_gen.sv | 159 +++++++++++++++
 tb/tb_sobel_window_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 neighbourhood generator feeding the Sobel stage.
// Pixels arrive in raster order; two line buffers supply the rows above the
// incoming pixel, and three 3-deep column shift registers hold the window.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready. A producer holds its payload stable while valid=1 and
// ready=0. pix_ready is combinational: !win_valid || win_ready, so a new pixel
// is only taken when the window register is empty or is being drained in the
// same cycle. Nothing is ever dropped or duplicated.
module sobel_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8,
    parameter int CW    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [CW-1:0]      ctr_row,
    output logic [CW-1:0]      ctr_col,
    output logic               frame_done
);

    // Line-buffer address width; the column counter is sliced down to this.
    localparam int AW = $clog2(IMG_W);

    localparam logic [CW-1:0] ONE          = CW'(1);
    localparam logic [CW-1:0] TWO          = CW'(2);
    localparam logic [CW-1:0] LAST_COL     = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW     = CW'(IMG_H - 1);
    localparam logic [CW-1:0] LAST_CTR_COL = CW'(IMG_W - 2);
    localparam logic [CW-1:0] LAST_CTR_ROW = CW'(IMG_H - 2);

    // Raster position of the pixel currently offered on pix_in.
    logic [CW-1:0] in_row_q, in_row_d;
    logic [CW-1:0] in_col_q, in_col_d;

    // Column shift registers: index 0 = leftmost (oldest) column, 2 = newest.
    logic [2:0][PIX_W-1:0] top_q, top_d;
    logic [2:0][PIX_W-1:0] mid_q, mid_d;
    logic [2:0][PIX_W-1:0] bot_q, bot_d;

    // Output-side registers.
    logic          win_valid_q, win_valid_d;
    logic [CW-1:0] ctr_row_q, ctr_row_d;
    logic [CW-1:0] ctr_col_q, ctr_col_d;
    logic          frame_done_q, frame_done_d;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (relative to in_row).
    logic [PIX_W-1:0] lb1_mem [IMG_W];
    logic [PIX_W-1:0] lb2_mem [IMG_W];

    logic [AW-1:0]    rd_idx;
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] lb2_rd;
    logic             pix_acc;
    logic             win_complete;
    logic             win_xfer;

    assign pix_ready    = !win_valid_q || win_ready;
    assign pix_acc      = pix_valid && pix_ready;
    assign win_xfer     = win_valid_q && win_ready;
    assign rd_idx       = in_col_q[AW-1:0];
    assign lb1_rd       = lb1_mem[rd_idx];
    assign lb2_rd       = lb2_mem[rd_idx];
    // An accept only completes a window once two full columns to the left and
    // two rows above exist; border-column accepts still feed the shifters,
    // which is why stale columns from the previous row never leak out.
    assign win_complete = pix_acc && (in_row_q >= TWO) && (in_col_q >= TWO);

    // Raster counter: advance column per accept, wrap to next row / next frame.
    always_comb begin
        in_row_d = in_row_q;
        in_col_d = in_col_q;
        if (pix_acc) begin
            if (in_col_q == LAST_COL) begin
                in_col_d = '0;
                if (in_row_q == LAST_ROW) begin
                    in_row_d = '0;
                end else begin
                    in_row_d = in_row_q + ONE;
                end
            end else begin
                in_col_d = in_col_q + ONE;
            end
        end
    end

    // Window datapath: shift in the new column (row r-2, r-1, r) on each accept
    // and track the output valid / centre / end-of-frame pulse.
    always_comb begin
        top_d        = top_q;
        mid_d        = mid_q;
        bot_d        = bot_q;
        win_valid_d  = win_valid_q;
        ctr_row_d    = ctr_row_q;
        ctr_col_d    = ctr_col_q;
        frame_done_d = win_xfer && (ctr_row_q == LAST_CTR_ROW)
                                && (ctr_col_q == LAST_CTR_COL);
        if (pix_acc) begin
            top_d = {lb2_rd, top_q[2], top_q[1]};
            mid_d = {lb1_rd, mid_q[2], mid_q[1]};
            bot_d = {pix_in, bot_q[2], bot_q[1]};
        end
        if (win_complete) begin
            win_valid_d = 1'b1;
            ctr_row_d   = in_row_q - ONE;
            ctr_col_d   = in_col_q - ONE;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_row_q     <= '0;
            in_col_q     <= '0;
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
            win_valid_q  <= 1'b0;
            ctr_row_q    <= '0;
            ctr_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            top_q        <= top_d;
            mid_q        <= mid_d;
            bot_q        <= bot_d;
            win_valid_q  <= win_valid_d;
            ctr_row_q    <= ctr_row_d;
            ctr_col_q    <= ctr_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line-buffer update: row r-1 ages into r-2, the new pixel becomes r-1.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb2_mem[rd_idx] <= lb1_rd;
            lb1_mem[rd_idx] <= pix_in;
        end
    end

    // P0..P2 = top row, P3..P5 = centre row, P6..P8 = bottom row, left to right.
    assign win        = {bot_q, mid_q, top_q};
    assign win_valid  = win_valid_q;
    assign ctr_row    = ctr_row_q;
    assign ctr_col    = ctr_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;

  localparam int W    = 64;
  localparam int H    = 64;
  localparam int NWIN = (H - 2) * (W - 2);
  localparam int EW   = 6 + 6 + 72;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [71:0] win;
  logic        win_valid;
  logic        win_ready;
  logic [5:0]  ctr_row;
  logic [5:0]  ctr_col;
  logic        frame_done;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .CW(6)) u_dut (
    .clk        (clk),
    .reset      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win        (win),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .ctr_row    (ctr_row),
    .ctr_col    (ctr_col),
    .frame_done (frame_done)
  );

  // ---------------- small DUT (5x4 image) ----------------
  logic [7:0]  s_pix_in;
  logic        s_pix_valid;
  logic        s_pix_ready;
  logic [71:0] s_win;
  logic        s_win_valid;
  logic        s_win_ready;
  logic [2:0]  s_ctr_row;
  logic [2:0]  s_ctr_col;
  logic        s_frame_done;

  sobel_window_gen #(.IMG_W(5), .IMG_H(4), .PIX_W(8), .CW(3)) u_small (
    .clk        (clk),
    .reset      (rst_n),
    .pix_in     (s_pix_in),
    .pix_valid  (s_pix_valid),
    .pix_ready  (s_pix_ready),
    .win        (s_win),
    .win_valid  (s_win_valid),
    .win_ready  (s_win_ready),
    .ctr_row    (s_ctr_row),
    .ctr_col    (s_ctr_col),
    .frame_done (s_frame_done)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];   // {ctr_row, ctr_col, win}
  int            lat_q[$];   // cycle stamp of the completing accept
  logic [77:0]   s_exp_q[$]; // small DUT: {ctr_row(3), ctr_col(3), win}
  logic [7:0]    img [H][W];
  int rdy_pct    = 100;
  int stall_left = 0;
  int win_cnt    = 0;
  int fd_cnt     = 0;
  int s_cnt      = 0;
  int s_fd       = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic abort_run(input string name);
    errors++;
    checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "stopped");
  endtask

  task automatic chk_reset_outs();
    chk("rst_win_valid", 128'(win_valid), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));
    chk("rst_win", 128'(win), 128'(0));
    chk("rst_ctr_row", 128'(ctr_row), 128'(0));
    chk("rst_ctr_col", 128'(ctr_col), 128'(0));
    chk("rst_pix_ready", 128'(pix_ready), 128'(1));
  endtask

  // Golden 3x3 extraction straight from the image array.
  function automatic logic [EW-1:0] golden(input int r, input int c);
    logic [EW-1:0] e;
    e = '0;
    for (int k = 0; k < 9; k++) e[k*8 +: 8] = img[r - 2 + k / 3][c - 2 + k % 3];
    e[83:78] = 6'(r - 1);
    e[77:72] = 6'(c - 1);
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_frame(input bit rnd, input int vpct, input int ab_r,
                            input int ab_c, input bit do_stall);
    int tries;
    bit accepted;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = rnd ? 8'($urandom_range(255)) : 8'((r * 64 + c) % 256);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == ab_r && c == ab_c) begin
          @(negedge clk);
          pix_valid = 1'b0;
          rst_n     = 1'b0;
          exp_q.delete();
          lat_q.delete();
          #1;
          chk_reset_outs();
          repeat (3) @(negedge clk);
          #1;
          chk_reset_outs();
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        accepted = 1'b0;
        tries    = 0;
        while (!accepted) begin
          @(negedge clk);
          pix_valid = ($urandom_range(99) < vpct);
          pix_in    = img[r][c];
          #1;
          if (pix_valid && pix_ready) begin
            accepted = 1'b1;
            if (r >= 2 && c >= 2) begin
              exp_q.push_back(golden(r, c));
              lat_q.push_back(cyc);
            end
            if (do_stall && r == 10 && c == 10) stall_left = 5;
          end
          tries++;
          if (tries > 1000) abort_run("pix_accept_timeout");
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    pix_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d windows still pending", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- monitor: random back-pressure and scoreboard pops ----------------
  initial begin
    logic          prev_stall;
    logic [EW-1:0] prev_out;
    logic [EW-1:0] e;
    bit            fd_exp;
    prev_stall = 1'b0;
    prev_out   = '0;
    fd_exp     = 1'b0;
    win_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = ($urandom_range(99) < rdy_pct);
      end
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
        fd_exp     = 1'b0;
        continue;
      end
      chk("pix_ready_rule", 128'(pix_ready), 128'(!win_valid || win_ready));
      chk("frame_done", 128'(frame_done), 128'(fd_exp));
      if (frame_done) fd_cnt++;
      fd_exp = 1'b0;
      if (prev_stall) begin
        chk("hold_valid", 128'(win_valid), 128'(1));
        chk("hold_window", 128'({ctr_row, ctr_col, win}), 128'(prev_out));
      end else if (win_valid) begin
        if (lat_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_window: ctr=(%0d,%0d) with empty queue", ctr_row, ctr_col);
        end else begin
          chk("latency", 128'(cyc - lat_q[0]), 128'(1));
        end
      end
      if (win_valid && win_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        void'(lat_q.pop_front());
        chk("window", 128'({ctr_row, ctr_col, win}), 128'(e));
        win_cnt++;
        if (e[83:78] == 6'(H - 2) && e[77:72] == 6'(W - 2)) fd_exp = 1'b1;
      end
      prev_stall = win_valid && !win_ready;
      prev_out   = {ctr_row, ctr_col, win};
    end
  end

  // ---------------- small-DUT monitor ----------------
  initial begin
    logic [77:0] se;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && s_win_valid && s_win_ready) begin
        if (s_exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL small_unexpected: ctr=(%0d,%0d)", s_ctr_row, s_ctr_col);
        end else begin
          se = s_exp_q.pop_front();
          chk("small_window", 128'({s_ctr_row, s_ctr_col, s_win}), 128'(se));
          s_cnt++;
        end
      end
      if (rst_n && s_frame_done) s_fd++;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    abort_run("global_watchdog");
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    logic [77:0] se;
    rst_n       = 1'b0;
    pix_valid   = 1'b0;
    pix_in      = '0;
    s_pix_valid = 1'b0;
    s_pix_in    = '0;
    s_win_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Two back-to-back ramp frames, no back-pressure.
    rdy_pct = 100; win_cnt = 0; fd_cnt = 0;
    send_frame(1'b0, 100, -1, -1, 1'b0);
    send_frame(1'b0, 100, -1, -1, 1'b0);
    drain();
    chk("count_two_frames", 128'(win_cnt), 128'(2 * NWIN));
    chk("frame_done_two_frames", 128'(fd_cnt), 128'(2));

    // Ramp frame with a 5-cycle downstream stall mid-frame.
    win_cnt = 0; fd_cnt = 0;
    send_frame(1'b0, 100, -1, -1, 1'b1);
    drain();
    chk("count_stall_frame", 128'(win_cnt), 128'(NWIN));
    chk("frame_done_stall_frame", 128'(fd_cnt), 128'(1));

    // Random pixels, 50% input gaps, 50% output back-pressure.
    rdy_pct = 50; win_cnt = 0; fd_cnt = 0;
    send_frame(1'b1, 50, -1, -1, 1'b0);
    drain();
    chk("count_random_frame", 128'(win_cnt), 128'(NWIN));
    chk("frame_done_random_frame", 128'(fd_cnt), 128'(1));

    // Reset at pixel (30,17), then a fresh ramp frame.
    rdy_pct = 100;
    send_frame(1'b0, 100, 30, 17, 1'b0);
    win_cnt = 0; fd_cnt = 0;
    send_frame(1'b0, 100, -1, -1, 1'b0);
    drain();
    chk("count_after_reset", 128'(win_cnt), 128'(NWIN));
    chk("frame_done_after_reset", 128'(fd_cnt), 128'(1));

    // 5x4 image: six windows with centres (1,1)..(2,3) in raster order.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        s_pix_valid = 1'b1;
        s_pix_in    = 8'(r * 16 + c);
        #1;
        chk("small_pix_ready", 128'(s_pix_ready), 128'(1));
        if (r >= 2 && c >= 2) begin
          se = '0;
          for (int k = 0; k < 9; k++) se[k*8 +: 8] = 8'((r - 2 + k / 3) * 16 + (c - 2 + k % 3));
          se[77:75] = 3'(r - 1);
          se[74:72] = 3'(c - 1);
          s_exp_q.push_back(se);
        end
      end
    end
    @(negedge clk);
    s_pix_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("small_count", 128'(s_cnt), 128'(6));
    chk("small_frame_done", 128'(s_fd), 128'(1));
    chk("small_queue_empty", 128'(s_exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
